classifier_seq_ctrl: RTL and testbench

CLASSIFIER_SEQ_CTRL -- requirements
Module: classifier_seq_ctrl

---
 rtl/classifier_pkg.sv | 20 ++
 rtl/reg_intN_clr_load.sv | 39 +++
 rtl/classifier_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_classifier_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/classifier_pkg.sv
// Shared types and widths for the classifier sequencer and its MAC partner.
package classifier_pkg;

  // Data widths on the MAC side: int4 features, int8 weights, 20-bit scores.
  localparam int X_BITS     = 4;
  localparam int W_BITS     = 8;
  localparam int SCORE_BITS = 20;

  // Default class-ID width (up to 8 classes).
  localparam int CLASS_BITS_DEFAULT = 3;

  // Sequencer states: wait, clear the MAC, stream features/weights, capture.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    FEED = 2'd2,
    CAPT = 2'd3
  } state_t;

endpackage

// File: rtl/reg_intN_clr_load.sv
// Generic N-bit register with synchronous reset, clear and load enable.
module reg_intN_clr_load #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear has priority over load; otherwise hold.
  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end
  end

  // State register with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/classifier_seq_ctrl.sv
// Sequencer for a class-by-class MAC classifier: clears the MAC, streams
// feature/weight addresses with a gapless N_FEAT+1 period per class,
// strobes the MAC, then captures the running argmax and max score.
module classifier_seq_ctrl
  import classifier_pkg::*;
#(
  parameter int N_FEAT     = 16,
  parameter int N_CLASS    = 8,
  parameter int CLASS_BITS = CLASS_BITS_DEFAULT,
  parameter int FA_BITS    = 4,
  parameter int WA_BITS    = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  // control
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  // memory read ports (1-cycle read latency)
  output logic [FA_BITS-1:0]           feat_addr,
  input  logic signed [X_BITS-1:0]     feat_rdata,
  output logic [WA_BITS-1:0]           w_addr,
  input  logic signed [W_BITS-1:0]     w_rdata,
  // MAC side
  output logic                         mac_rst,
  output logic signed [X_BITS-1:0]     x_int4,
  output logic signed [W_BITS-1:0]     w_int8,
  output logic                         new_feat,
  output logic                         new_class,
  output logic [CLASS_BITS-1:0]        class_id,
  input  logic [CLASS_BITS-1:0]        max_class,
  input  logic signed [SCORE_BITS-1:0] max_score,
  // result
  output logic [CLASS_BITS-1:0]        result_class,
  output logic signed [SCORE_BITS-1:0] result_score,
  output logic                         result_valid
);

  localparam logic [FA_BITS-1:0]    FEAT_LAST  = FA_BITS'(N_FEAT - 1);
  localparam logic [CLASS_BITS-1:0] CLASS_LAST = CLASS_BITS'(N_CLASS - 1);
  localparam logic [WA_BITS-1:0]    W_LAST     = WA_BITS'(N_CLASS * N_FEAT - 1);

  state_t                 state_q, state_d;
  logic [FA_BITS-1:0]     feat_cnt_q, feat_cnt_d;
  logic [CLASS_BITS-1:0]  class_cnt_q, class_cnt_d;
  logic [WA_BITS-1:0]     w_cnt_q, w_cnt_d;
  // gap: the slot after a class's last address, where its last new_feat fires.
  logic                   gap_q, gap_d;
  // drain: the slot carrying the final new_class, before CAPT.
  logic                   drain_q, drain_d;
  logic                   new_feat_q, new_feat_d;
  logic                   new_class_q, new_class_d;
  logic [CLASS_BITS-1:0]  class_id_q, class_id_d;
  logic                   done_q, done_d;
  logic                   result_valid_q, result_valid_d;
  logic                   capt;

  // Next-state, counter and strobe logic; strobes are registered so each
  // lands exactly one cycle after the slot that produced it.
  always_comb begin
    state_d        = state_q;
    feat_cnt_d     = feat_cnt_q;
    class_cnt_d    = class_cnt_q;
    w_cnt_d        = w_cnt_q;
    gap_d          = gap_q;
    drain_d        = drain_q;
    new_feat_d     = 1'b0;
    new_class_d    = 1'b0;
    class_id_d     = '0;
    done_d         = 1'b0;
    result_valid_d = result_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = CLR;
          result_valid_d = 1'b0;
        end
      end

      CLR: begin
        feat_cnt_d  = '0;
        class_cnt_d = '0;
        w_cnt_d     = '0;
        gap_d       = 1'b0;
        drain_d     = 1'b0;
        state_d     = FEED;
      end

      FEED: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = CAPT;
        end else if (gap_q) begin
          // Close the current class; the next class's first address issues
          // in the same cycle as this new_class.
          gap_d       = 1'b0;
          new_class_d = 1'b1;
          class_id_d  = class_cnt_q;
          if (class_cnt_q == CLASS_LAST) begin
            class_cnt_d = '0;
            drain_d     = 1'b1;
          end else begin
            class_cnt_d = class_cnt_q + 1'b1;
          end
        end else begin
          // Address-issue slot; data returns next cycle with new_feat.
          new_feat_d = 1'b1;
          if (feat_cnt_q == FEAT_LAST) begin
            feat_cnt_d = '0;
            gap_d      = 1'b1;
          end else begin
            feat_cnt_d = feat_cnt_q + 1'b1;
          end
          w_cnt_d = (w_cnt_q == W_LAST) ? '0 : w_cnt_q + 1'b1;
        end
      end

      CAPT: begin
        done_d         = 1'b1;
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM, counters and strobe registers; reset clears everything at any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      feat_cnt_q     <= '0;
      class_cnt_q    <= '0;
      w_cnt_q        <= '0;
      gap_q          <= 1'b0;
      drain_q        <= 1'b0;
      new_feat_q     <= 1'b0;
      new_class_q    <= 1'b0;
      class_id_q     <= '0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      feat_cnt_q     <= feat_cnt_d;
      class_cnt_q    <= class_cnt_d;
      w_cnt_q        <= w_cnt_d;
      gap_q          <= gap_d;
      drain_q        <= drain_d;
      new_feat_q     <= new_feat_d;
      new_class_q    <= new_class_d;
      class_id_q     <= class_id_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign capt = (state_q == CAPT);

  reg_intN_clr_load #(.WIDTH(CLASS_BITS)) u_result_class (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .load (capt),
    .d    (max_class),
    .q    (result_class)
  );

  reg_intN_clr_load #(.WIDTH(SCORE_BITS)) u_result_score (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .load (capt),
    .d    (max_score),
    .q    (result_score)
  );

  assign busy         = (state_q != IDLE);
  assign mac_rst      = (state_q == CLR);
  assign done         = done_q;
  assign result_valid = result_valid_q;
  assign feat_addr    = feat_cnt_q;
  assign w_addr       = w_cnt_q;
  assign new_feat     = new_feat_q;
  assign new_class    = new_class_q;
  assign class_id     = class_id_q;
  assign x_int4       = feat_rdata;
  assign w_int8       = w_rdata;

endmodule

// File: tb/tb_classifier_seq_ctrl.sv
// Directed bench for classifier_seq_ctrl (N_FEAT=4, N_CLASS=3) with
// behavioural feature/weight memories and a behavioural MAC/argmax partner.
module tb_classifier_seq_ctrl;

  localparam int NF = 4;
  localparam int NC = 3;
  localparam int CB = 3;
  localparam int FA = 2;
  localparam int WA = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                busy, done;
  logic [FA-1:0]       feat_addr;
  logic signed [3:0]   feat_rdata = '0;
  logic [WA-1:0]       w_addr;
  logic signed [7:0]   w_rdata = '0;
  logic                mac_rst;
  logic signed [3:0]   x_int4;
  logic signed [7:0]   w_int8;
  logic                new_feat, new_class;
  logic [CB-1:0]       class_id;
  logic [CB-1:0]       max_class = '0;
  logic signed [19:0]  max_score = '0;
  logic [CB-1:0]       result_class;
  logic signed [19:0]  result_score;
  logic                result_valid;

  classifier_seq_ctrl #(
    .N_FEAT(NF), .N_CLASS(NC), .CLASS_BITS(CB), .FA_BITS(FA), .WA_BITS(WA)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .feat_addr(feat_addr), .feat_rdata(feat_rdata),
    .w_addr(w_addr), .w_rdata(w_rdata),
    .mac_rst(mac_rst), .x_int4(x_int4), .w_int8(w_int8),
    .new_feat(new_feat), .new_class(new_class), .class_id(class_id),
    .max_class(max_class), .max_score(max_score),
    .result_class(result_class), .result_score(result_score),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle read latency.
  logic signed [3:0] feat_mem [NF];
  logic signed [7:0] w_mem [NF*NC];

  always @(posedge clk) begin
    feat_rdata <= feat_mem[feat_addr];
    w_rdata    <= w_mem[w_addr];
  end

  // Behavioural MAC: accumulate on new_feat, keep strict running max
  // (starting at class 0 / score 0) on new_class, clear on mac_rst.
  logic signed [19:0] acc = '0;
  logic signed [19:0] x_ext, w_ext;
  assign x_ext = 20'(x_int4);
  assign w_ext = 20'(w_int8);

  always @(posedge clk) begin
    if (mac_rst) begin
      acc       <= '0;
      max_score <= '0;
      max_class <= '0;
    end else begin
      if (new_feat) acc <= acc + x_ext * w_ext;
      if (new_class) begin
        acc <= '0;
        if (acc > max_score) begin
          max_score <= acc;
          max_class <= class_id;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Check bookkeeping.
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Protocol monitor, sampling on the falling edge.
  int t0 = 0;
  bit mon_en = 1'b0;
  int mac_rst_rel[$];
  int nc_rel[$];
  int nc_id[$];
  int done_rel[$];
  int wseq[$];
  int first_nf;
  int nf_between, nf_bad, overlap, busy_bad;
  int nf_total, nc_total, mr_total;
  logic rv_at1;
  logic [WA-1:0] prev_w = '0;

  always @(negedge clk) begin : monitor
    int rel;
    rel = cyc - t0;
    if (mon_en) begin
      if (new_feat && new_class) overlap++;
      if (new_feat) begin
        nf_between++;
        nf_total++;
        wseq.push_back(int'(prev_w));
        if (first_nf < 0) first_nf = rel;
      end
      if (new_class) begin
        nc_total++;
        nc_rel.push_back(rel);
        nc_id.push_back(int'(class_id));
        if (nf_between != NF) nf_bad++;
        nf_between = 0;
      end
      if (mac_rst) begin
        mr_total++;
        mac_rst_rel.push_back(rel);
      end
      if (done) done_rel.push_back(rel);
      if (rel == 1) rv_at1 = result_valid;
      if (rel <= 19 && busy !== (rel >= 1 && rel <= 18)) busy_bad++;
    end
    prev_w = w_addr;
  end

  task automatic clear_monitor();
    mac_rst_rel.delete(); nc_rel.delete(); nc_id.delete();
    done_rel.delete(); wseq.delete();
    first_nf = -1; nf_between = 0; nf_bad = 0; overlap = 0; busy_bad = 0;
    nf_total = 0; nc_total = 0; mr_total = 0; rv_at1 = 1'bx;
  endtask

  task automatic load_mems(input int fval, input int w0, input int w1, input int w2);
    for (int f = 0; f < NF; f++) begin
      feat_mem[f]       = 4'(fval);
      w_mem[0*NF + f]   = 8'(w0);
      w_mem[1*NF + f]   = 8'(w1);
      w_mem[2*NF + f]   = 8'(w2);
    end
  endtask

  // Raise start inside the current cycle (cycle 0), away from any edge.
  task automatic start_run(input bit hold);
    #1;
    clear_monitor();
    t0     = cyc;
    start  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int k;
    k = 0;
    while (done_rel.size() < n && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_done_count"}, done_rel.size(), n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},         busy,         0);
    check({tag, "_done"},         done,         0);
    check({tag, "_new_feat"},     new_feat,     0);
    check({tag, "_new_class"},    new_class,    0);
    check({tag, "_mac_rst"},      mac_rst,      0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_class_id"},     class_id,     0);
    check({tag, "_feat_addr"},    feat_addr,    0);
    check({tag, "_w_addr"},       w_addr,       0);
    check({tag, "_result_class"}, result_class, 0);
    check({tag, "_result_score"}, result_score, 0);
  endtask

  task automatic check_schedule(input string tag);
    check({tag, "_mac_rst_cyc"}, (mac_rst_rel.size() > 0) ? mac_rst_rel[0] : -1, 1);
    check({tag, "_first_nf_cyc"}, first_nf, 3);
    check({tag, "_nc_count"}, nc_rel.size(), 3);
    for (int c = 0; c < NC; c++) begin
      check({tag, "_nc_cyc"}, (nc_rel.size() > c) ? nc_rel[c] : -1, 7 + 5 * c);
      check({tag, "_nc_id"},  (nc_id.size()  > c) ? nc_id[c]  : -1, c);
    end
    check({tag, "_done_cyc"}, (done_rel.size() > 0) ? done_rel[0] : -1, 19);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_nf_per_class"}, nf_bad, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clear_monitor();
    load_mems(1, 1, 3, 2);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Single inference: scores 4, 12, 8 -> class 1, score 12.
    @(negedge clk);
    start_run(1'b0);
    wait_done(1, "single");
    check_schedule("single");
    check("single_mac_rst_count", mac_rst_rel.size(), 1);
    check("single_busy_window", busy_bad, 0);
    check("single_result_class", result_class, 1);
    check("single_result_score", result_score, 12);
    check("single_result_valid", result_valid, 1);
    check("single_w_seq_len", wseq.size(), NF * NC);
    for (int i = 0; i < NF * NC; i++)
      check("single_w_seq", (wseq.size() > i) ? wseq[i] : -1, i);

    // Back-to-back, all scores negative: result must not inherit 12.
    load_mems(1, -1, -1, -1);
    start_run(1'b0);
    wait_done(1, "neg");
    check_schedule("neg");
    check("neg_rv_cleared", rv_at1, 0);
    check("neg_busy_window", busy_bad, 0);
    check("neg_result_class", result_class, 0);
    check("neg_result_score", result_score, 0);
    check("neg_result_valid", result_valid, 1);

    // start held high for 50 cycles: one inference per IDLE visit.
    load_mems(1, 1, 3, 2);
    @(negedge clk);
    start_run(1'b1);
    while (cyc - t0 < 50) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(3, "held");
    check("held_mac_rst_count", mac_rst_rel.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("held_mac_rst_cyc", (mac_rst_rel.size() > i) ? mac_rst_rel[i] : -1, 1 + 19 * i);
      check("held_done_cyc",    (done_rel.size() > i)    ? done_rel[i]    : -1, 19 + 19 * i);
    end
    check("held_nf_per_class", nf_bad, 0);
    check("held_result_score", result_score, 12);

    // Reset in the middle of class 1, then a fresh inference.
    @(negedge clk);
    start_run(1'b0);
    while (cyc - t0 < 9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b0;
    nf_total = 0; nc_total = 0; mr_total = 0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_new_feat", nf_total, 0);
    check("post_rst_new_class", nc_total, 0);
    check("post_rst_mac_rst", mr_total, 0);
    @(negedge clk);
    start_run(1'b0);
    wait_done(1, "after_rst");
    check_schedule("after_rst");
    check("after_rst_result_class", result_class, 1);
    check("after_rst_result_score", result_score, 12);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
